// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC rotation scheduler.
// The tag travels alongside each datapath slot to say who owns the result and whether it was bypassed.
package cordic_pkg;

  localparam int W         = 32;
  localparam int AW        = 32;
  localparam int LATENCY   = 17;
  localparam int BYP_DEPTH = 4;

  localparam logic [31:0] DUMMY_A  = 32'h0000_0000;
  localparam logic [31:0] DUMMY_B  = 32'h0000_0001;
  localparam logic [31:0] DUMMY_P  = 32'h0000_0000;
  localparam logic [31:0] DUMMY_Q  = 32'h0000_0000;
  localparam logic [31:0] ANGLE_45 = 32'h02D0_0000;

  typedef struct packed {
    logic v;
    logic id;
    logic byp;
  } tag_t;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cordic_byp_fifo.sv
// Small synchronous FIFO holding {a,p,q} of requests that skip the datapath because b==0.
// A push into a full FIFO or a pop from an empty one is ignored.
module cordic_byp_fifo
  import cordic_pkg::*;
#(
  parameter int DW    = 3 * W,
  parameter int DEPTH = BYP_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_count == (PW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_mem[r_rdPtr];

  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_rot_sched.sv
// Round-robin front end sharing one pipelined doubly-rotating CORDIC between two requesters.
// b==0 requests never reach the datapath; they are parked in a FIFO and replayed in their pipeline slot.
module cordic_rot_sched
  import cordic_pkg::*;
#(
  parameter int W         = cordic_pkg::W,
  parameter int AW        = cordic_pkg::AW,
  parameter int LATENCY   = cordic_pkg::LATENCY,
  parameter int BYP_DEPTH = cordic_pkg::BYP_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_req_valid,
  output logic [1:0]      o_req_ready,
  input  logic [2*W-1:0]  i_req_a,
  input  logic [2*W-1:0]  i_req_b,
  input  logic [2*W-1:0]  i_req_p,
  input  logic [2*W-1:0]  i_req_q,
  output logic [1:0]      o_rsp_valid,
  output logic [W-1:0]    o_rsp_a,
  output logic [W-1:0]    o_rsp_b,
  output logic [W-1:0]    o_rsp_p,
  output logic [W-1:0]    o_rsp_q,
  output logic [AW-1:0]   o_rsp_angle,
  output logic [W-1:0]    o_dp_a,
  output logic [W-1:0]    o_dp_b,
  output logic [W-1:0]    o_dp_p,
  output logic [W-1:0]    o_dp_q,
  input  logic [W-1:0]    i_dp_af,
  input  logic [W-1:0]    i_dp_bf,
  input  logic [W-1:0]    i_dp_pf,
  input  logic [W-1:0]    i_dp_qf,
  input  logic [AW-1:0]   i_dp_angle,
  output logic [4:0]      o_inflight
);

  logic          r_rr;
  tag_t          r_tag [LATENCY+1];

  logic [1:0]    w_bZero;
  logic [1:0]    w_elig;
  logic [1:0]    w_grant;
  logic          w_xfer;
  logic          w_gid;
  logic [W-1:0]  w_selA;
  logic [W-1:0]  w_selB;
  logic [W-1:0]  w_selP;
  logic [W-1:0]  w_selQ;
  logic          w_selByp;
  tag_t          w_tagIn;
  tag_t          w_tagOut;
  logic          w_pop;
  logic          w_fifoFull;
  logic          w_fifoEmpty;
  logic [3*W-1:0] w_fifoData;

  assign w_bZero[0] = (i_req_b[W-1:0] == '0);
  assign w_bZero[1] = (i_req_b[2*W-1:W] == '0);

  // Fullness is judged on the registered count only, so a pop this cycle never frees a slot early.
  assign w_elig[0] = i_req_valid[0] && (!w_bZero[0] || !w_fifoFull);
  assign w_elig[1] = i_req_valid[1] && (!w_bZero[1] || !w_fifoFull);

  always_comb begin
    w_grant = 2'b00;
    if (w_elig == 2'b11) begin
      w_grant = id_to_onehot(r_rr);
    end else begin
      w_grant = w_elig;
    end
  end

  assign o_req_ready = w_grant;
  assign w_xfer      = |w_grant;
  assign w_gid       = w_grant[1];

  assign w_selA   = w_gid ? i_req_a[2*W-1:W] : i_req_a[W-1:0];
  assign w_selB   = w_gid ? i_req_b[2*W-1:W] : i_req_b[W-1:0];
  assign w_selP   = w_gid ? i_req_p[2*W-1:W] : i_req_p[W-1:0];
  assign w_selQ   = w_gid ? i_req_q[2*W-1:W] : i_req_q[W-1:0];
  assign w_selByp = w_xfer && (w_selB == '0);

  assign w_tagIn.v   = w_xfer;
  assign w_tagIn.id  = w_gid;
  assign w_tagIn.byp = w_selByp;

  assign w_tagOut = r_tag[LATENCY];
  assign w_pop    = w_tagOut.v && w_tagOut.byp && !w_fifoEmpty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr <= 1'b0;
    end else if (w_xfer) begin
      r_rr <= ~w_gid;
    end
  end

  // Only genuine b!=0 operands reach the datapath; every other slot carries the b=1 dummy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dp_a <= W'(DUMMY_A);
      o_dp_b <= W'(DUMMY_B);
      o_dp_p <= W'(DUMMY_P);
      o_dp_q <= W'(DUMMY_Q);
    end else if (w_xfer && !w_selByp) begin
      o_dp_a <= w_selA;
      o_dp_b <= w_selB;
      o_dp_p <= w_selP;
      o_dp_q <= w_selQ;
    end else begin
      o_dp_a <= W'(DUMMY_A);
      o_dp_b <= W'(DUMMY_B);
      o_dp_p <= W'(DUMMY_P);
      o_dp_q <= W'(DUMMY_Q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= LATENCY; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= w_tagIn;
      for (int k = 1; k <= LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  cordic_byp_fifo #(
    .DW    (3 * W),
    .DEPTH (BYP_DEPTH)
  ) u_bypFifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_selByp),
    .i_pop   (w_pop),
    .i_data  ({w_selA, w_selP, w_selQ}),
    .o_data  (w_fifoData),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // The exiting tag lines up with the datapath output register; its data is held between pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 2'b00;
      o_rsp_a     <= '0;
      o_rsp_b     <= '0;
      o_rsp_p     <= '0;
      o_rsp_q     <= '0;
      o_rsp_angle <= '0;
    end else begin
      o_rsp_valid <= 2'b00;
      if (w_tagOut.v) begin
        o_rsp_valid <= id_to_onehot(w_tagOut.id);
        if (w_tagOut.byp) begin
          o_rsp_a     <= w_fifoData[3*W-1:2*W];
          o_rsp_b     <= '0;
          o_rsp_p     <= w_fifoData[2*W-1:W];
          o_rsp_q     <= w_fifoData[W-1:0];
          o_rsp_angle <= '0;
        end else begin
          o_rsp_a     <= i_dp_af;
          o_rsp_b     <= i_dp_bf;
          o_rsp_p     <= i_dp_pf;
          o_rsp_q     <= i_dp_qf;
          o_rsp_angle <= i_dp_angle;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inflight <= '0;
    end else begin
      case ({w_tagIn.v, w_tagOut.v})
        2'b10:   o_inflight <= o_inflight + 5'd1;
        2'b01:   o_inflight <= o_inflight - 5'd1;
        default: o_inflight <= o_inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rot_sched.sv
// Self-checking bench for cordic_rot_sched with a behavioural 17-cycle CORDIC datapath.
// Expected results are queued at each accepted request and checked when the matching pulse appears.
module tb_cordic_rot_sched;
  import cordic_pkg::*;

  localparam int LAT       = 17;
  localparam int RSP_DELAY = 19;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] q;
    logic [31:0] ang;
  } res_t;

  typedef struct {
    logic [1:0] owner;
    res_t       exp;
    bit         tol;
    int         due;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0, req_b = '0, req_p = '0, req_q = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_a, rsp_b, rsp_p, rsp_q, rsp_angle;
  logic [31:0] dp_a, dp_b, dp_p, dp_q;
  logic [31:0] dp_af, dp_bf, dp_pf, dp_qf, dp_angle;
  logic [4:0]  inflight;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   dpbZero = 0;
  sb_t  sb[$];
  res_t pipe [LAT];

  always #5 clk = ~clk;

  cordic_rot_sched dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_p     (req_p),
    .i_req_q     (req_q),
    .o_rsp_valid (rsp_valid),
    .o_rsp_a     (rsp_a),
    .o_rsp_b     (rsp_b),
    .o_rsp_p     (rsp_p),
    .o_rsp_q     (rsp_q),
    .o_rsp_angle (rsp_angle),
    .o_dp_a      (dp_a),
    .o_dp_b      (dp_b),
    .o_dp_p      (dp_p),
    .o_dp_q      (dp_q),
    .i_dp_af     (dp_af),
    .i_dp_bf     (dp_bf),
    .i_dp_pf     (dp_pf),
    .i_dp_qf     (dp_qf),
    .i_dp_angle  (dp_angle),
    .o_inflight  (inflight)
  );

  function automatic logic [31:0] to_fx(input real x);
    int v;
    v = $rtoi(x * 1048576.0 + ((x < 0.0) ? -0.5 : 0.5));
    return v;
  endfunction

  // Ideal gain-compensated rotation: drives b to zero, rotates (p,q) by the same angle.
  function automatic res_t dp_model(input logic [31:0] a, b, p, q);
    res_t r;
    real ra, rb, rp, rq, th, c, s;
    ra = $itor($signed(a)) / 1048576.0;
    rb = $itor($signed(b)) / 1048576.0;
    rp = $itor($signed(p)) / 1048576.0;
    rq = $itor($signed(q)) / 1048576.0;
    th = $atan2(rb, ra);
    c  = $cos(th);
    s  = $sin(th);
    r.a   = to_fx($sqrt(ra * ra + rb * rb));
    r.b   = to_fx(-ra * s + rb * c);
    r.p   = to_fx(rp * c + rq * s);
    r.q   = to_fx(-rp * s + rq * c);
    r.ang = to_fx(th * 180.0 / 3.14159265358979);
    return r;
  endfunction

  function automatic int absdiff(input logic [31:0] x, input logic [31:0] y);
    int d;
    d = $signed(x) - $signed(y);
    return (d < 0) ? -d : d;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= dp_model(dp_a, dp_b, dp_p, dp_q);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign dp_af    = pipe[LAT-1].a;
  assign dp_bf    = pipe[LAT-1].b;
  assign dp_pf    = pipe[LAT-1].p;
  assign dp_qf    = pipe[LAT-1].q;
  assign dp_angle = pipe[LAT-1].ang;

  // Response scoreboard: every pulse must match the oldest outstanding request, on time.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (dp_b == 32'd0) dpbZero++;
    if (rst_n) begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        tests++; fails++;
        $display("[TB] FAIL rsp_missing: no pulse by cycle %0d, expected at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL rsp_unexpected: rsp_valid=%b at cycle %0d, expected none", rsp_valid, cyc);
        end else begin
          e = sb.pop_front();
          tests++;
          if (rsp_valid !== e.owner) begin
            fails++;
            $display("[TB] FAIL rsp_owner: got %b expected %b", rsp_valid, e.owner);
          end
          tests++;
          if (cyc !== e.due) begin
            fails++;
            $display("[TB] FAIL rsp_latency: pulse at cycle %0d expected %0d", cyc, e.due);
          end
          if (e.tol) begin
            tests++;
            if (absdiff(rsp_a, e.exp.a) > 32'h40 || absdiff(rsp_b, 32'd0) > 32'h40 ||
                absdiff(rsp_angle, e.exp.ang) > 32'h100 || rsp_p !== 32'd0 || rsp_q !== 32'd0) begin
              fails++;
              $display("[TB] FAIL rsp_rot45: got a=%h b=%h p=%h q=%h ang=%h expected a~%h b~0 p=0 q=0 ang~%h",
                       rsp_a, rsp_b, rsp_p, rsp_q, rsp_angle, e.exp.a, e.exp.ang);
            end
          end else begin
            tests++;
            if ({rsp_a, rsp_b, rsp_p, rsp_q, rsp_angle} !== e.exp) begin
              fails++;
              $display("[TB] FAIL rsp_data: got a=%h b=%h p=%h q=%h ang=%h expected a=%h b=%h p=%h q=%h ang=%h",
                       rsp_a, rsp_b, rsp_p, rsp_q, rsp_angle,
                       e.exp.a, e.exp.b, e.exp.p, e.exp.q, e.exp.ang);
            end
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, b, p, q);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_p[i*32 +: 32] = p;
    req_q[i*32 +: 32] = q;
    req_valid[i] = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [31:0] a, b, p, q, input bit tol);
    sb_t e;
    e.owner = (i == 0) ? 2'b01 : 2'b10;
    e.tol   = tol;
    e.due   = cyc + RSP_DELAY;
    if (tol) begin
      e.exp = '0;
      e.exp.a = 32'h0016A09E;
      e.exp.ang = ANGLE_45;
    end else if (b == 32'd0) begin
      e.exp = {a, 32'd0, p, q, 32'd0};
    end else begin
      e.exp = dp_model(a, b, p, q);
    end
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 2'b00;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    tests++;
    if ({rsp_valid, rsp_a, rsp_b, rsp_p, rsp_q, rsp_angle} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_rsp: got valid=%b a=%h b=%h angle=%h expected all zero", rsp_valid, rsp_a, rsp_b, rsp_angle);
    end
    tests++;
    if ({dp_a, dp_b, dp_p, dp_q} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
      fails++;
      $display("[TB] FAIL reset_dp: got a=%h b=%h p=%h q=%h expected 0,1,0,0", dp_a, dp_b, dp_p, dp_q);
    end
    tests++;
    if (inflight !== 5'd0) begin
      fails++;
      $display("[TB] FAIL reset_inflight: got %0d expected 0", inflight);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("[TB] FAIL idle_ready: got %b expected 00", req_ready);
    end
    set_req(1, 32'h100, 32'd0, 32'h1, 32'h2);
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("[TB] FAIL ready_single_r1: got %b expected 10", req_ready);
    end
    set_req(0, 32'h100, 32'h100, 32'h0, 32'h0);
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("[TB] FAIL ready_tie_ptr0: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    set_req(0, 32'h00100000, 32'h00100000, 32'd0, 32'd0);
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("[TB] FAIL single_ready: got %b expected 01", req_ready);
    end
    if (req_ready[0]) push_exp(0, 32'h00100000, 32'h00100000, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    drain();
  endtask

  task automatic test_round_robin();
    logic [31:0] ops [2][4];
    logic [1:0]  expReady;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ops[i][0] = $urandom_range(32'h40000, 32'h3FFFFF);
      ops[i][1] = $urandom_range(32'h1, 32'h3FFFFF);
      ops[i][2] = $urandom_range(32'h0, 32'hFFFFF);
      ops[i][3] = $urandom_range(32'h0, 32'hFFFFF);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) set_req(i, ops[i][0], ops[i][1], ops[i][2], ops[i][3]);
      #1;
      expReady = (c % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (req_ready !== expReady) begin
        fails++;
        $display("[TB] FAIL rr_grant%0d: got %b expected %b", c, req_ready, expReady);
      end
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          push_exp(i, ops[i][0], ops[i][1], ops[i][2], ops[i][3], 1'b0);
          ops[i][0] = $urandom_range(32'h40000, 32'h3FFFFF);
          ops[i][1] = $urandom_range(32'h1, 32'h3FFFFF);
        end
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    tests++;
    if (inflight !== 5'd6) begin
      fails++;
      $display("[TB] FAIL rr_inflight: got %0d expected 6", inflight);
    end
    drain();
    tests++;
    if (inflight !== 5'd0) begin
      fails++;
      $display("[TB] FAIL rr_inflight_drained: got %0d expected 0", inflight);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    set_req(1, 32'h00200000, 32'd0, 32'h00050000, 32'h00030000);
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("[TB] FAIL byp_ready: got %b expected 10", req_ready);
    end
    if (req_ready[1]) push_exp(1, 32'h00200000, 32'd0, 32'h00050000, 32'h00030000, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    tests++;
    if (dp_b !== 32'd1) begin
      fails++;
      $display("[TB] FAIL byp_dp_dummy: dp_b got %h expected 1", dp_b);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    int t1 = 0;
    int n = 0;
    logic [31:0] a5 = 32'h00555000;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_req(0, 32'h00010000 * (k + 1), 32'd0, 32'h1000 + k, 32'h2000 + k);
      #1;
      if (k == 0) t1 = cyc;
      tests++;
      if (req_ready !== 2'b01) begin
        fails++;
        $display("[TB] FAIL fifo_fill%0d: got %b expected 01", k, req_ready);
      end
      if (req_ready[0]) push_exp(0, 32'h00010000 * (k + 1), 32'd0, 32'h1000 + k, 32'h2000 + k, 1'b0);
    end
    @(negedge clk);
    set_req(0, a5, 32'd0, 32'h777, 32'h888);
    set_req(1, 32'h00300000, 32'h00100000, 32'h00010000, 32'h0);
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("[TB] FAIL fifo_full_ready: got %b expected 10", req_ready);
    end
    if (req_ready[1]) push_exp(1, 32'h00300000, 32'h00100000, 32'h00010000, 32'h0, 1'b0);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    while (!req_ready[0] && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    tests++;
    if (!req_ready[0] || cyc != t1 + RSP_DELAY) begin
      fails++;
      $display("[TB] FAIL fifo_unblock: ready=%b at cycle %0d expected ready at %0d", req_ready, cyc, t1 + RSP_DELAY);
    end
    if (req_ready[0]) push_exp(0, a5, 32'd0, 32'h777, 32'h888, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    drain();
  endtask

  task automatic test_reset_midop();
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = 2'b00;
      if (c % 2 == 0) set_req(1, 32'h00040000 + c, 32'd0, 32'h100, 32'h200);
      else set_req(0, 32'h00080000 + c, 32'h00020000, 32'h300, 32'h400);
      #1;
      for (int i = 0; i < 2; i++)
        if (req_ready[i]) push_exp(i, req_a[i*32 +: 32], req_b[i*32 +: 32], req_p[i*32 +: 32], req_q[i*32 +: 32], 1'b0);
    end
    @(negedge clk);
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    tests++;
    if ({rsp_valid, inflight} !== 7'd0 || {dp_a, dp_b, dp_p, dp_q} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
      fails++;
      $display("[TB] FAIL midop_reset: got rsp_valid=%b inflight=%0d dp_a=%h dp_b=%h expected 0,0,0,1",
               rsp_valid, inflight, dp_a, dp_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("[TB] FAIL midop_silence: got %0d pulses after release expected 0", pulses);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_req(1, 32'h00011000 + k, 32'd0, 32'h5, 32'h6);
      #1;
      tests++;
      if (req_ready !== 2'b10) begin
        fails++;
        $display("[TB] FAIL midop_fifo_cleared%0d: got %b expected 10", k, req_ready);
      end
      if (req_ready[1]) push_exp(1, 32'h00011000 + k, 32'd0, 32'h5, 32'h6, 1'b0);
    end
    @(negedge clk);
    req_valid = 2'b00;
    drain();
  endtask

  task automatic test_idle();
    int pulses = 0;
    int badB = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00) pulses++;
      if (dp_b !== 32'd1) badB++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("[TB] FAIL idle_rsp: got %0d pulses expected 0", pulses);
    end
    tests++;
    if (badB != 0) begin
      fails++;
      $display("[TB] FAIL idle_dp_b: got %0d cycles with dp_b!=1 expected 0", badB);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bypass();
    test_fifo_full();
    test_reset_midop();
    test_idle();
    tests++;
    if (dpbZero != 0) begin
      fails++;
      $display("[TB] FAIL dp_b_nonzero: got %0d cycles with dp_b==0 expected 0", dpbZero);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish by 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
